data_mem_responder: RTL and testbench

Bus responder for the CPU data port: a single-port 16-bit word memory behind the `stb`/`we`/`ack` handshake that the CPU core drives as initiator. It samples a strobed request, inserts a fixed number of wait states, commits writes or returns read data, and pulses `ack` for exactly one cycle. It sits between the CPU data bus and on-chip data storage, and is the counterpart of the CPU's data-side master logic.

---
 rtl/data_mem_responder.sv | 127 ++++++++++++
 tb/tb_data_mem_responder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Wait-stated 16-bit word memory responder for the CPU data bus (stb/we/ack).
// Optional build macro DMEM_RANGE_CHECK_EN flags and blocks out-of-range addresses.
module data_mem_responder #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] data_addr_i,
    input  logic [15:0] data_data_i,
    input  logic        data_stb_i,
    input  logic        data_we_i,
    output logic [15:0] data_data_o,
    output logic        data_ack_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [15:0] OOR_DATA = 16'hDEAD;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_we;

    logic [15:0] mem [2**AW];

    logic        commit;
    logic        mem_we;
    logic [15:0] c_addr;
    logic [15:0] c_wdata;
    logic        c_we;
    logic [AW-1:0] c_idx;
    logic        oor;

    // With zero wait states the commit happens on the latch edge,
    // so the live bus values stand in for the latched copies.
    always_comb begin
        c_addr  = lat_addr;
        c_wdata = lat_wdata;
        c_we    = lat_we;
        commit  = 1'b0;
        case (state)
            S_IDLE: begin
                c_addr  = data_addr_i;
                c_wdata = data_data_i;
                c_we    = data_we_i;
                commit  = data_stb_i && (WAIT_CYCLES == 0);
            end
            S_WAIT: commit = (cnt == 4'd0);
            default: commit = 1'b0;
        endcase
    end

    assign c_idx = c_addr[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
    assign oor = (c_addr >> AW) != 16'h0000;
`else
    logic unused_hi;
    assign unused_hi = |(c_addr >> AW);
    assign oor       = 1'b0;
`endif

    assign mem_we = commit && c_we && !oor && !sys_rst;

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            mem[c_idx] <= c_wdata;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            lat_addr    <= 16'h0000;
            lat_wdata   <= 16'h0000;
            lat_we      <= 1'b0;
            data_ack_o  <= 1'b0;
            data_data_o <= 16'h0000;
            err_o       <= 1'b0;
        end else begin
            data_ack_o <= 1'b0;
            err_o      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (data_stb_i) begin
                        lat_addr  <= data_addr_i;
                        lat_wdata <= data_data_i;
                        lat_we    <= data_we_i;
                        if (WAIT_CYCLES == 0) begin
                            state <= S_ACK;
                        end else begin
                            cnt   <= CNT_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_ACK;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                data_ack_o <= 1'b1;
                err_o      <= oor;
                if (!c_we) begin
                    data_data_o <= oor ? OOR_DATA : mem[c_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2 and 3 wait states),
// table-driven requests and a per-instance scoreboard checked on every ack.
module tb_data_mem_responder;

    typedef struct {
        int          inst;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst   [3];
    logic [15:0] addr  [3];
    logic [15:0] wdata [3];
    logic        stb   [3];
    logic        we    [3];
    logic [15:0] rdata [3];
    logic        ack   [3];
    logic        err   [3];

    int          wc [3];
    logic [15:0] last_rd [3];
    exp_t        sb [3][$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.AW(10), .WAIT_CYCLES(0)) u_w0 (
        .sys_clk(clk), .sys_rst(rst[0]),
        .data_addr_i(addr[0]), .data_data_i(wdata[0]),
        .data_stb_i(stb[0]), .data_we_i(we[0]),
        .data_data_o(rdata[0]), .data_ack_o(ack[0]), .err_o(err[0])
    );

    data_mem_responder #(.AW(10), .WAIT_CYCLES(2)) u_w2 (
        .sys_clk(clk), .sys_rst(rst[1]),
        .data_addr_i(addr[1]), .data_data_i(wdata[1]),
        .data_stb_i(stb[1]), .data_we_i(we[1]),
        .data_data_o(rdata[1]), .data_ack_o(ack[1]), .err_o(err[1])
    );

    data_mem_responder #(.AW(10), .WAIT_CYCLES(3)) u_w3 (
        .sys_clk(clk), .sys_rst(rst[2]),
        .data_addr_i(addr[2]), .data_data_i(wdata[2]),
        .data_stb_i(stb[2]), .data_we_i(we[2]),
        .data_data_o(rdata[2]), .data_ack_o(ack[2]), .err_o(err[2])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int i, input int c,
                            input logic [15:0] d, input logic e);
        exp_t x;
        x.cyc  = c;
        x.data = d;
        x.err  = e;
        sb[i].push_back(x);
    endtask

    // Every ack is matched against the oldest expected completion.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ack[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ack inst %0d: got ack 1, expected 0 (cycle %0d)",
                             i, cyc);
                end else begin
                    exp_t e;
                    e = sb[i].pop_front();
                    chk($sformatf("ack_cycle[%0d]", i), cyc, e.cyc);
                    chk($sformatf("rdata[%0d]", i), {16'h0, rdata[i]},
                        {16'h0, e.data});
                    chk($sformatf("err[%0d]", i), {31'h0, err[i]},
                        {31'h0, e.err});
                end
            end
        end
    end

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (sb[i].size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout inst %0d: got %0d pending, expected 0",
                     i, sb[i].size());
            sb[i].delete();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int i;
        i = v.inst;
        @(posedge clk);
        #1;
        addr[i]  = v.addr;
        wdata[i] = v.wdata;
        we[i]    = v.we;
        stb[i]   = 1'b1;
        if (v.we) begin
            push_exp(i, cyc + 1 + wc[i], last_rd[i], v.err);
        end else begin
            push_exp(i, cyc + 1 + wc[i], v.rdata, v.err);
            last_rd[i] = v.rdata;
        end
        @(posedge clk);
        #1;
        stb[i] = 1'b0;
        wdata[i] = 16'hFFFF;
        addr[i]  = 16'h0000;
        wait_done(i);
    endtask

    task automatic chk_idle_outs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_ack[%0d]", tag, i), {31'h0, ack[i]}, 32'h0);
            chk($sformatf("%s_data[%0d]", tag, i), {16'h0, rdata[i]}, 32'h0);
            chk($sformatf("%s_err[%0d]", tag, i), {31'h0, err[i]}, 32'h0);
        end
    endtask

    vec_t tbl [11];

    initial begin
        wc = '{0, 2, 3};
        for (int i = 0; i < 3; i++) begin
            rst[i]     = 1'b1;
            addr[i]    = 16'h0;
            wdata[i]   = 16'h0;
            stb[i]     = 1'b0;
            we[i]      = 1'b0;
            last_rd[i] = 16'h0;
        end

        tbl[0]  = '{1, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0};
        tbl[1]  = '{1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0};
        tbl[2]  = '{2, 1'b1, 16'h0009, 16'h5555, 16'h0000, 1'b0};
        tbl[3]  = '{2, 1'b0, 16'h0009, 16'h0000, 16'h5555, 1'b0};
        tbl[4]  = '{0, 1'b1, 16'h03FF, 16'hCAFE, 16'h0000, 1'b0};
        tbl[5]  = '{0, 1'b0, 16'h03FF, 16'h0000, 16'hCAFE, 1'b0};
        tbl[6]  = '{0, 1'b1, 16'h0000, 16'h0A0B, 16'h0000, 1'b0};
        tbl[7]  = '{0, 1'b0, 16'h0000, 16'h0000, 16'h0A0B, 1'b0};
        tbl[8]  = '{1, 1'b1, 16'h0405, 16'h0F0F, 16'h0000, RC};
        tbl[9]  = '{1, 1'b0, 16'h0005, 16'h0000,
                    RC ? 16'h1234 : 16'h0F0F, 1'b0};
        tbl[10] = '{1, 1'b0, 16'h0405, 16'h0000,
                    RC ? 16'hDEAD : 16'h0F0F, RC};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outs("in_reset");
        #1;
        for (int i = 0; i < 3; i++) rst[i] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_idle_outs("post_reset");

        for (int k = 0; k < 11; k++) begin
            run_vec(tbl[k]);
        end

        // Zero wait states, stb held high across a write then a read.
        @(posedge clk);
        #1;
        addr[0]  = 16'h0007;
        wdata[0] = 16'hBEEF;
        we[0]    = 1'b1;
        stb[0]   = 1'b1;
        push_exp(0, cyc + 1, last_rd[0], 1'b0);
        push_exp(0, cyc + 3, 16'hBEEF, 1'b0);
        last_rd[0] = 16'hBEEF;
        @(posedge clk);
        #1;
        we[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        stb[0] = 1'b0;
        wait_done(0);

        // Reset while the three-wait-state write is pending.
        @(posedge clk);
        #1;
        addr[2]  = 16'h0009;
        wdata[2] = 16'hAAAA;
        we[2]    = 1'b1;
        stb[2]   = 1'b1;
        @(posedge clk);
        #1;
        stb[2] = 1'b0;
        rst[2] = 1'b1;
        @(negedge clk);
        chk("midwait_rst_ack", {31'h0, ack[2]}, 32'h0);
        chk("midwait_rst_data", {16'h0, rdata[2]}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst[2]     = 1'b0;
        last_rd[2] = 16'h0;
        repeat (8) @(posedge clk);
        begin
            vec_t v;
            v = '{2, 1'b0, 16'h0009, 16'h0000, 16'h5555, 1'b0};
            run_vec(v);
        end

        repeat (4) @(posedge clk);
        for (int i = 0; i < 3; i++) wait_done(i);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
